// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: a single-beat core port
// and a burst DMA port, with round-robin arbitration in IDLE and bounded core wait.
module dmem_arbiter #(
  parameter int unsigned ADDR_WORDS = 64,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic        c_err,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_len,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic       StIdle  = 1'b0;
  localparam logic       StBurst = 1'b1;
  localparam logic [7:0] WaitMax = 8'(MAX_WAIT);

  logic        r_state;
  logic        r_last;
  logic [31:0] r_base;
  logic [3:0]  r_len;
  logic [3:0]  r_beat;
  logic [7:0]  r_wait;
  logic        r_c_rvalid;
  logic        r_c_err;
  logic [31:0] r_c_rdata;
  logic        r_d_rvalid;
  logic        r_d_err;
  logic        r_d_done;
  logic [31:0] r_d_rdata;

  logic        w_c_gnt;
  logic        w_d_gnt;
  logic [31:0] w_d_addr;
  logic        w_c_err;
  logic        w_d_err;
  logic        w_d_last;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= ADDR_WORDS);
  endfunction

  // Inside a burst the address comes from the captured base, never from d_addr.
  assign w_d_addr = (r_state == StBurst) ? (r_base + {26'd0, r_beat, 2'b00}) : d_addr;
  assign w_c_err  = addr_bad(c_addr);
  assign w_d_err  = addr_bad(w_d_addr);
  assign w_d_last = (r_state == StIdle) ? (d_len == 4'd0) : (r_beat == r_len);

  always_comb begin
    w_c_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!reset) begin
      if (r_state == StIdle) begin
        if (c_req && d_req) begin
          w_c_gnt = r_last;
          w_d_gnt = !r_last;
        end else begin
          w_c_gnt = c_req;
          w_d_gnt = d_req;
        end
      end else if (c_req && (r_wait == WaitMax)) begin
        w_c_gnt = 1'b1;
      end else begin
        w_d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_a  = 32'd0;
    mem_wd = 32'd0;
    mem_we = 1'b0;
    if (w_c_gnt) begin
      mem_a  = c_addr;
      mem_wd = c_wdata;
      mem_we = c_we && !w_c_err;
    end else if (w_d_gnt) begin
      mem_a  = w_d_addr;
      mem_wd = d_wdata;
      mem_we = d_we && !w_d_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_last     <= 1'b1;
      r_base     <= 32'd0;
      r_len      <= 4'd0;
      r_beat     <= 4'd0;
      r_wait     <= 8'd0;
      r_c_rvalid <= 1'b0;
      r_c_err    <= 1'b0;
      r_c_rdata  <= 32'd0;
      r_d_rvalid <= 1'b0;
      r_d_err    <= 1'b0;
      r_d_done   <= 1'b0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_c_rvalid <= w_c_gnt;
      r_c_err    <= w_c_gnt && w_c_err;
      r_d_rvalid <= w_d_gnt;
      r_d_err    <= w_d_gnt && w_d_err;
      r_d_done   <= w_d_gnt && w_d_last;
      if (w_c_gnt) begin
        r_c_rdata <= (c_we || w_c_err) ? 32'd0 : mem_rd;
      end
      if (w_d_gnt) begin
        r_d_rdata <= (d_we || w_d_err) ? 32'd0 : mem_rd;
      end
      if (w_c_gnt || w_d_gnt) begin
        r_last <= w_d_gnt;
      end

      if (r_state == StIdle) begin
        r_wait <= 8'd0;
        if (w_d_gnt) begin
          r_base <= d_addr;
          r_len  <= d_len;
          r_beat <= 4'd1;
          if (d_len != 4'd0) begin
            r_state <= StBurst;
          end
        end
      end else if (w_c_gnt) begin
        // Core took this slot; the skipped beat is retried next cycle.
        r_wait <= 8'd0;
      end else begin
        r_wait <= c_req ? (r_wait + 8'd1) : 8'd0;
        r_beat <= r_beat + 4'd1;
        if (w_d_last) begin
          r_state <= StIdle;
        end
      end
    end
  end

  assign c_gnt    = w_c_gnt;
  assign c_rvalid = r_c_rvalid;
  assign c_err    = r_c_err;
  assign c_rdata  = r_c_rdata;
  assign d_gnt    = w_d_gnt;
  assign d_rvalid = r_d_rvalid;
  assign d_err    = r_d_err;
  assign d_done   = r_d_done;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word memory behind the
// memory port; inputs change on negedge, outputs are sampled at negedge or #1 after.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we;
  logic [31:0] c_addr, c_wdata;
  logic        c_gnt, c_rvalid, c_err;
  logic [31:0] c_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_len;
  logic        d_gnt, d_rvalid, d_err, d_done;
  logic [31:0] d_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [64];

  dmem_arbiter #(
    .ADDR_WORDS(64),
    .MAX_WAIT  (4)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .c_req   (c_req),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_gnt   (c_gnt),
    .c_rvalid(c_rvalid),
    .c_err   (c_err),
    .c_rdata (c_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_len   (d_len),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_err   (d_err),
    .d_done  (d_done),
    .d_rdata (d_rdata),
    .mem_we  (mem_we),
    .mem_a   (mem_a),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd)
  );

  always #5 clk = ~clk;

  // Index aliases on the low address bits so a leaked out-of-range write is visible.
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    reset = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'd0; c_wdata = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_len = 4'd0;

    // Reset: requests are ignored and every output is zero.
    repeat (2) @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'h1111_2222;
    #1;
    check_eq("rst c_gnt", c_gnt, 0);
    check_eq("rst mem_we", mem_we, 0);
    check_eq("rst mem_a", mem_a, 0);
    check_eq("rst mem_wd", mem_wd, 0);
    @(negedge clk);
    c_req = 1'b0; c_we = 1'b0;
    check_eq("rst c_rvalid", c_rvalid, 0);
    check_eq("rst c_err", c_err, 0);
    check_eq("rst c_rdata", c_rdata, 0);
    check_eq("rst d_rvalid", d_rvalid, 0);
    check_eq("rst d_done", d_done, 0);
    check_eq("rst d_err", d_err, 0);
    check_eq("rst d_rdata", d_rdata, 0);
    check_eq("rst mem[4]", mem[4], init_word(4));
    reset = 1'b0;

    // Core write then read back.
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("cw c_gnt", c_gnt, 1);
    check_eq("cw mem_we", mem_we, 1);
    check_eq("cw mem_a", mem_a, 32'h10);
    @(negedge clk);
    check_eq("cw c_rvalid", c_rvalid, 1);
    check_eq("cw c_err", c_err, 0);
    c_we = 1'b0;
    #1;
    check_eq("cr c_gnt", c_gnt, 1);
    check_eq("cr mem_we", mem_we, 0);
    @(negedge clk);
    c_req = 1'b0;
    check_eq("cr c_rvalid", c_rvalid, 1);
    check_eq("cr c_rdata", c_rdata, 32'hDEAD_BEEF);
    check_eq("cr c_err", c_err, 0);
    @(negedge clk);
    check_eq("cr rvalid pulse", c_rvalid, 0);

    // Single-beat DMA read (d_len = 0).
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_len = 4'd0;
    #1;
    check_eq("d0 d_gnt", d_gnt, 1);
    check_eq("d0 c_gnt", c_gnt, 0);
    @(negedge clk);
    d_req = 1'b0;
    check_eq("d0 d_rvalid", d_rvalid, 1);
    check_eq("d0 d_done", d_done, 1);
    check_eq("d0 d_rdata", d_rdata, 32'hDEAD_BEEF);
    check_eq("d0 d_err", d_err, 0);
    #1;
    check_eq("d0 idle d_gnt", d_gnt, 0);
    @(negedge clk);
    check_eq("d0 done pulse", d_done, 0);

    // Contention with last = 1: core, DMA, core, DMA.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14; d_len = 4'd0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check_eq("rr c_gnt", c_gnt, 32'((k % 2) == 0));
      check_eq("rr d_gnt", d_gnt, 32'((k % 2) == 1));
    end
    @(negedge clk);
    c_req = 1'b0; d_req = 1'b0;

    // DMA write burst of 4 beats at 0x20; d_addr is scrambled after beat 0.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_len = 4'd3; d_wdata = 32'd1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        check_eq("b4 d_rvalid", d_rvalid, 1);
        check_eq("b4 early done", d_done, 0);
        d_req = 1'b0; d_addr = 32'hFC; d_wdata = 32'(k + 1);
      end
      #1;
      check_eq("b4 d_gnt", d_gnt, 1);
      check_eq("b4 mem_a", mem_a, 32'(32'h20 + 4 * k));
      check_eq("b4 mem_we", mem_we, 1);
    end
    @(negedge clk);
    d_we = 1'b0;
    check_eq("b4 last rvalid", d_rvalid, 1);
    check_eq("b4 d_done", d_done, 1);
    check_eq("b4 end d_gnt", d_gnt, 0);
    for (int i = 0; i < 4; i++) check_eq("b4 mem", mem[8 + i], 32'(i + 1));

    // 16-beat burst; core waits from beat 1, wins the slot after 4 waiting cycles.
    @(negedge clk);
    for (int t = 0; t <= 16; t++) begin
      int beat;
      beat = (t < 5) ? t : t - 1;
      if (t > 0) begin
        @(negedge clk);
        check_eq("b16 early done", d_done, 0);
      end
      if (t == 6) begin
        check_eq("b16 c_rvalid", c_rvalid, 1);
        check_eq("b16 c_rdata", c_rdata, 32'hDEAD_BEEF);
        check_eq("b16 no beat", d_rvalid, 0);
      end
      d_req = (t == 0); d_we = 1'b1; d_addr = (t == 0) ? 32'h40 : 32'h0; d_len = 4'd15;
      d_wdata = 32'(32'h100 + beat);
      c_req = (t >= 1) && (t <= 5); c_we = 1'b0; c_addr = 32'h10;
      #1;
      if (t == 5) begin
        check_eq("b16 core c_gnt", c_gnt, 1);
        check_eq("b16 core d_gnt", d_gnt, 0);
        check_eq("b16 core mem_a", mem_a, 32'h10);
      end else begin
        check_eq("b16 d_gnt", d_gnt, 1);
        check_eq("b16 c_gnt", c_gnt, 0);
        check_eq("b16 mem_a", mem_a, 32'(32'h40 + 4 * beat));
      end
    end
    @(negedge clk);
    c_req = 1'b0; d_we = 1'b0;
    check_eq("b16 d_done", d_done, 1);
    check_eq("b16 last rvalid", d_rvalid, 1);
    for (int i = 0; i < 16; i++) check_eq("b16 mem", mem[16 + i], 32'(32'h100 + i));

    // Misaligned read and out-of-range write.
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h13;
    #1;
    check_eq("e1 c_gnt", c_gnt, 1);
    check_eq("e1 mem_we", mem_we, 0);
    @(negedge clk);
    check_eq("e1 c_rvalid", c_rvalid, 1);
    check_eq("e1 c_err", c_err, 1);
    check_eq("e1 c_rdata", c_rdata, 0);
    c_we = 1'b1; c_addr = 32'h100; c_wdata = 32'h1234_5678;
    #1;
    check_eq("e2 c_gnt", c_gnt, 1);
    check_eq("e2 mem_we", mem_we, 0);
    @(negedge clk);
    c_req = 1'b0; c_we = 1'b0;
    check_eq("e2 c_rvalid", c_rvalid, 1);
    check_eq("e2 c_err", c_err, 1);
    check_eq("e2 c_rdata", c_rdata, 0);
    check_eq("e2 mem[0]", mem[0], init_word(0));
    check_eq("e2 mem[4]", mem[4], 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("e2 err pulse", c_err, 0);

    // Reset on beat 2 of a 6-beat write burst at 0x80.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_len = 4'd5; d_wdata = 32'h200;
    #1;
    check_eq("rb beat0 d_gnt", d_gnt, 1);
    @(negedge clk);
    d_req = 1'b0; d_wdata = 32'h201;
    #1;
    check_eq("rb beat1 d_gnt", d_gnt, 1);
    @(negedge clk);
    check_eq("rb beat1 rvalid", d_rvalid, 1);
    reset = 1'b1; d_wdata = 32'h202;
    #1;
    check_eq("rb rst d_gnt", d_gnt, 0);
    check_eq("rb rst mem_we", mem_we, 0);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rb d_rvalid", d_rvalid, 0);
    check_eq("rb d_done", d_done, 0);
    check_eq("rb d_err", d_err, 0);
    check_eq("rb d_rdata", d_rdata, 0);
    check_eq("rb c_rvalid", c_rvalid, 0);
    check_eq("rb c_rdata", c_rdata, 0);
    check_eq("rb mem_a", mem_a, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("rb after d_gnt", d_gnt, 0);
      check_eq("rb after mem_we", mem_we, 0);
      @(negedge clk);
      check_eq("rb after d_done", d_done, 0);
    end
    check_eq("rb mem32", mem[32], 32'h200);
    check_eq("rb mem33", mem[33], 32'h201);
    for (int i = 34; i < 38; i++) check_eq("rb mem untouched", mem[i], init_word(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
